// File: rtl/project_top_pkg.sv
// project_top_pkg: shared types and constants for the guess-the-hex game.
package project_top_pkg;

    typedef enum logic [1:0] {IDLE, PLAY, GAME_OVER} state_t;

    localparam logic [7:0] LFSR_SEED = 8'h01;
    // Taps for x^8+x^6+x^5+x^4+1 in a left-shifting register (bits 7,5,4,3).
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_OVER  = 7'b1001001;
    localparam logic [5:0] SCORE_MAX = 6'd63;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/project_top_seg7_hex.sv
// seg7_hex: hex digit to active-high 7-segment pattern {g,f,e,d,c,b,a}.
module seg7_hex (
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'h00;
        case (i_hex)
            4'h0: o_seg = 7'h3F;
            4'h1: o_seg = 7'h06;
            4'h2: o_seg = 7'h5B;
            4'h3: o_seg = 7'h4F;
            4'h4: o_seg = 7'h66;
            4'h5: o_seg = 7'h6D;
            4'h6: o_seg = 7'h7D;
            4'h7: o_seg = 7'h07;
            4'h8: o_seg = 7'h7F;
            4'h9: o_seg = 7'h6F;
            4'hA: o_seg = 7'h77;
            4'hB: o_seg = 7'h7C;
            4'hC: o_seg = 7'h39;
            4'hD: o_seg = 7'h5E;
            4'hE: o_seg = 7'h79;
            default: o_seg = 7'h71;
        endcase
    end

endmodule

// File: rtl/project_top.sv
// project_top: guess-the-hex game; match the shown digit on ui_in[7:4] and press.
module project_top
    import project_top_pkg::*;
#(
    parameter int START_LIVES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [1:0] LIVES0 = 2'(START_LIVES);

    logic       r_sync1, r_sync2, r_prev;
    logic [7:0] r_lfsr;
    state_t     r_state;
    logic [5:0] r_score;
    logic [1:0] r_lives;
    logic [3:0] r_target;
    logic       r_led;

    state_t     w_state_n;
    logic [5:0] w_score_n;
    logic [1:0] w_lives_n;
    logic [3:0] w_target_n;
    logic       w_led_n;
    logic       w_press;
    logic       w_hit;
    logic [6:0] w_hex;
    logic [6:0] w_seg;
    logic       w_unused;

    assign w_unused = &{1'b0, ena, uio_in, ui_in[3:1]};
    assign w_press  = r_sync2 & ~r_prev;
    // The answer is sampled raw: the player holds it steady before pressing.
    assign w_hit    = ui_in[7:4] == r_target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_prev   <= 1'b0;
            r_lfsr   <= LFSR_SEED;
            r_state  <= IDLE;
            r_score  <= 6'd0;
            r_lives  <= LIVES0;
            r_target <= 4'd0;
            r_led    <= 1'b0;
        end else begin
            r_sync1  <= ui_in[0];
            r_sync2  <= r_sync1;
            r_prev   <= r_sync2;
            r_lfsr   <= lfsr_next(r_lfsr);
            r_state  <= w_state_n;
            r_score  <= w_score_n;
            r_lives  <= w_lives_n;
            r_target <= w_target_n;
            r_led    <= w_led_n;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_score_n  = r_score;
        w_lives_n  = r_lives;
        w_target_n = r_target;
        w_led_n    = r_led;
        if (w_press) begin
            case (r_state)
                IDLE: begin
                    w_state_n  = PLAY;
                    w_target_n = r_lfsr[3:0];
                    w_score_n  = 6'd0;
                    w_lives_n  = LIVES0;
                    w_led_n    = 1'b0;
                end
                PLAY: begin
                    if (w_hit) begin
                        w_score_n  = (r_score == SCORE_MAX) ? r_score : r_score + 6'd1;
                        w_target_n = r_lfsr[3:0];
                        w_led_n    = 1'b1;
                    end else begin
                        w_led_n   = 1'b0;
                        w_lives_n = r_lives - 2'd1;
                        w_state_n = (r_lives == 2'd1) ? GAME_OVER : PLAY;
                    end
                end
                default: w_state_n = IDLE;
            endcase
        end
    end

    seg7_hex u_hex (
        .i_hex(r_target),
        .o_seg(w_hex)
    );

    assign w_seg   = (r_state == PLAY) ? w_hex : (r_state == GAME_OVER) ? SEG_OVER : SEG_DASH;
    assign uo_out  = {(r_state == PLAY) & r_led, w_seg};
    assign uio_out = {r_lives, r_score};
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_project_top.sv
// tb_project_top: table-driven and scoreboarded check of the guess-the-hex game.
module tb_project_top;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    project_top #(.START_LIVES(3)) dut (
        .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    logic [7:0] m_lfsr;
    always @(posedge clk or posedge rst)
        if (rst) m_lfsr <= 8'h01;
        else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};

    typedef struct {string name; logic [7:0] uo; logic [7:0] uio;} exp_t;
    typedef struct {string name; bit correct; logic [7:0] uio;} vec_t;
    exp_t sb[$];
    vec_t tbl[8];

    int n_vec = 0, n_err = 0;
    int         g_state;
    logic [5:0] g_score;
    logic [1:0] g_lives;
    logic [3:0] g_target;
    logic       g_led;

    function automatic logic [6:0] glyph(input logic [3:0] h);
        case (h)
            4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
            4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
            4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
            4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    function automatic logic [7:0] exp_uo();
        return g_state == 1 ? {g_led, glyph(g_target)} : g_state == 2 ? 8'h49 : 8'h40;
    endfunction

    function automatic logic [7:0] exp_uio();
        return {g_lives, g_score};
    endfunction

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        g_state = 0; g_score = 0; g_lives = 3; g_target = 0; g_led = 0;
    endtask

    task automatic model_step(input logic [3:0] ans, input logic [3:0] lo);
        if (g_state == 0) begin
            g_state = 1; g_target = lo; g_score = 0; g_lives = 3; g_led = 0;
        end else if (g_state == 1) begin
            if (ans == g_target) begin
                if (g_score != 6'd63) g_score = g_score + 6'd1;
                g_target = lo; g_led = 1;
            end else begin
                g_led = 0;
                if (g_lives == 2'd1) g_state = 2;
                g_lives = g_lives - 2'd1;
            end
        end else g_state = 0;
    endtask

    // Button is already high in the synchronizer input; act on the third edge.
    task automatic await_act(input string nm);
        exp_t e;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check({nm, ".early"}, uo_out, exp_uo());
        model_step(ui_in[7:4], m_lfsr[3:0]);
        sb.push_back('{nm, exp_uo(), exp_uio()});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({e.name, ".uo"}, uo_out, e.uo);
        check({e.name, ".uio"}, uio_out, e.uio);
    endtask

    task automatic do_press(input string nm, input logic [3:0] ans, input int extra);
        @(negedge clk);
        ui_in = {ans, 3'b000, 1'b1};
        await_act(nm);
        repeat (extra) @(posedge clk);
        @(negedge clk);
        ui_in[0] = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        ui_in = 8'h00;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{"start",   1'b0, 8'hC0};
        tbl[1] = '{"hit1",    1'b1, 8'hC1};
        tbl[2] = '{"hit2",    1'b1, 8'hC2};
        tbl[3] = '{"miss1",   1'b0, 8'h82};
        tbl[4] = '{"hit3",    1'b1, 8'h83};
        tbl[5] = '{"miss2",   1'b0, 8'h43};
        tbl[6] = '{"miss3",   1'b0, 8'h03};
        tbl[7] = '{"to_idle", 1'b0, 8'h03};
        uio_in = 8'($urandom);
        apply_reset();
        #1;
        check("rst.uo", uo_out, 8'h40);
        check("rst.uio", uio_out, 8'hC0);
        check("rst.oe", uio_oe, 8'hFF);
        repeat (10) @(posedge clk);
        #1;
        check("idle_hold.uo", uo_out, 8'h40);
        check("idle_hold.uio", uio_out, 8'hC0);

        for (int i = 0; i < 8; i++) begin
            do_press(tbl[i].name, tbl[i].correct ? g_target : g_target ^ 4'h1, 0);
            check({tbl[i].name, ".tbl"}, uio_out, tbl[i].uio);
        end
        check("idle_after_go", uo_out, 8'h40);

        do_press("start2", 4'h0, 0);
        for (int i = 0; i < 64; i++) do_press("sat_hit", g_target, 0);
        check("sat.score", uio_out, 8'hFF);
        check("sat.led", {7'd0, uo_out[7]}, 8'h01);
        for (int i = 0; i < 3; i++) do_press("sat_miss", g_target ^ 4'h1, 0);
        check("over.uo", uo_out, 8'h49);
        do_press("over_exit", 4'h0, 0);
        check("over_exit.uo", uo_out, 8'h40);
        check("over_exit.uio", uio_out, 8'h3F);

        do_press("start3", 4'h0, 0);
        do_press("long_hold", g_target, 6);
        check("long_hold.uio", uio_out, 8'hC1);
        for (int i = 0; i < 4; i++) do_press("to_five", g_target, 0);
        check("five.uio", uio_out, 8'hC5);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst.uo", uo_out, 8'h40);
        check("async_rst.uio", uio_out, 8'hC0);
        check("async_rst.oe", uio_oe, 8'hFF);
        model_reset();

        ui_in = 8'h01;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        await_act("held_at_release");
        check("held.uio", uio_out, 8'hC0);
        @(negedge clk);
        ui_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("held.single", uio_out, 8'hC0);
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
